// File: rtl/score_pkg.sv
// Shared BCD constants and elaboration-time helpers for the score bank.
package score_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  // Packs up to four decimal digits of v into BCD, LSD in the low nibble.
  function automatic logic [15:0] to_bcd(int v, int n);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < n; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Ceiling log2 usable in localparam expressions.
  function automatic int unsigned clog2(int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bcd_chain.sv
// One channel: ripple-carry BCD counter with saturate or wrap on overflow.
module bcd_chain
  import score_pkg::*;
#(
  parameter int unsigned N_DIG = 2,
  parameter bit          WRAP  = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   en_inc,
  output logic [N_DIG*BCD_W-1:0] q,
  output logic [N_DIG*BCD_W-1:0] nxt
);

  logic carry;

  // Candidate next value when en is set; used both for commit and win compare.
  always_comb begin
    nxt   = q;
    carry = en;
    for (int d = 0; d < int'(N_DIG); d++) begin
      if (carry) begin
        if (q[d*BCD_W +: BCD_W] == BCD_MAX) begin
          nxt[d*BCD_W +: BCD_W] = '0;
        end else begin
          nxt[d*BCD_W +: BCD_W] = 4'(q[d*BCD_W +: BCD_W] + 4'd1);
          carry = 1'b0;
        end
      end
    end
    // Carry out of the top digit means the chain was all-9s.
    if (carry && !WRAP) nxt = q;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en_inc) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/bcd_score_bank.sv
// Multi-channel BCD scoreboard with win detection, game-over lock and overflow mode.
module bcd_score_bank
  import score_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned N_DIG     = 2,
  parameter int unsigned WIN_SCORE = 11,
  parameter int unsigned WRAP      = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CH-1:0]             inc,
  input  logic                        clr,
  output logic [N_CH*N_DIG*BCD_W-1:0] digits,
  output logic                        game_over,
  output logic [N_CH-1:0]             winner,
  output logic                        win_pulse
);

  localparam int unsigned CH_W = N_DIG * BCD_W;
  localparam logic [CH_W-1:0] WIN_BCD = CH_W'(to_bcd(int'(WIN_SCORE), int'(N_DIG)));
  localparam bit WIN_EN = (WIN_SCORE != 0);

  logic [N_CH-1:0] hit;
  logic [N_CH-1:0] win_oh;
  logic            found;

  for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
    logic [CH_W-1:0] nxt;

    bcd_chain #(
      .N_DIG (N_DIG),
      .WRAP  (WRAP != 0)
    ) u_chain (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .en     (inc[c]),
      .en_inc (inc[c] & ~game_over),
      .q      (digits[c*CH_W +: CH_W]),
      .nxt    (nxt)
    );

    assign hit[c] = WIN_EN && !game_over && inc[c] && (nxt == WIN_BCD);
  end

  // Lowest-index channel wins a tie.
  always_comb begin
    win_oh = '0;
    found  = 1'b0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (hit[c] && !found) begin
        win_oh[c] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      game_over <= 1'b0;
      winner    <= '0;
      win_pulse <= 1'b0;
    end else begin
      win_pulse <= 1'b0;
      if (!game_over && found) begin
        game_over <= 1'b1;
        winner    <= win_oh;
        win_pulse <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_score_bank.sv
// Directed bench for bcd_score_bank: three configurations driven in lockstep against a scoreboard.
module tb_bcd_score_bank;

  typedef struct {
    logic [15:0] d;
    logic        g;
    logic [1:0]  w;
    logic        p;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] inc;
  logic       clr;

  logic [15:0] dg [3];
  logic        go_o [3];
  logic [1:0]  wn_o [3];
  logic        wp_o [3];

  int   checks   = 0;
  int   failures = 0;

  // Configurations: 0 = saturate/no win, 1 = wrap/no win, 2 = saturate/win at 11.
  int   win_cfg  [3] = '{0, 0, 11};
  int   wrap_cfg [3] = '{0, 1, 0};

  int   sc   [3][2];
  bit   m_go [3];
  logic [1:0] m_wn [3];
  bit   m_p  [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  bcd_score_bank #(.N_CH(2), .N_DIG(2), .WIN_SCORE(0), .WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .inc(inc), .clr(clr),
    .digits(dg[0]), .game_over(go_o[0]), .winner(wn_o[0]), .win_pulse(wp_o[0]));

  bcd_score_bank #(.N_CH(2), .N_DIG(2), .WIN_SCORE(0), .WRAP(1)) u_wrap (
    .clk(clk), .reset(reset), .inc(inc), .clr(clr),
    .digits(dg[1]), .game_over(go_o[1]), .winner(wn_o[1]), .win_pulse(wp_o[1]));

  bcd_score_bank #(.N_CH(2), .N_DIG(2), .WIN_SCORE(11), .WRAP(0)) u_win (
    .clk(clk), .reset(reset), .inc(inc), .clr(clr),
    .digits(dg[2]), .game_over(go_o[2]), .winner(wn_o[2]), .win_pulse(wp_o[2]));

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic exp_t model_step(input int k, input logic [1:0] i, input logic c, input logic r);
    exp_t e;
    if (r || c) begin
      sc[k][0] = 0; sc[k][1] = 0;
      m_go[k] = 1'b0; m_wn[k] = 2'b00; m_p[k] = 1'b0;
    end else begin
      m_p[k] = 1'b0;
      if (!m_go[k]) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (i[ch]) sc[k][ch] = (sc[k][ch] == 99) ? ((wrap_cfg[k] != 0) ? 0 : 99) : sc[k][ch] + 1;
        end
        if (win_cfg[k] != 0) begin
          for (int ch = 0; ch < 2; ch++) begin
            if (!m_go[k] && i[ch] && sc[k][ch] == win_cfg[k]) begin
              m_go[k] = 1'b1;
              m_wn[k] = 2'(1 << ch);
              m_p[k]  = 1'b1;
            end
          end
        end
      end
    end
    e.d = '0;
    for (int ch = 0; ch < 2; ch++) e.d[ch*8 +: 8] = {4'(sc[k][ch] / 10), 4'(sc[k][ch] % 10)};
    e.g = m_go[k];
    e.w = m_wn[k];
    e.p = m_p[k];
    return e;
  endfunction

  task automatic compare(input int k, input exp_t e);
    check("digits",    k, 32'(dg[k]),   32'(e.d));
    check("game_over", k, 32'(go_o[k]), 32'(e.g));
    check("winner",    k, 32'(wn_o[k]), 32'(e.w));
    check("win_pulse", k, 32'(wp_o[k]), 32'(e.p));
  endtask

  // One clock: drive on the falling edge, push expectations, check after the rising edge.
  task automatic step(input logic [1:0] i, input logic c, input logic r);
    exp_t e;
    @(negedge clk);
    inc = i; clr = c; reset = r;
    q0.push_back(model_step(0, i, c, r));
    q1.push_back(model_step(1, i, c, r));
    q2.push_back(model_step(2, i, c, r));
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0) || (k == 2 && q2.size() == 0)) begin
        failures++;
        $display("FAIL scoreboard_empty dut%0d observed=0 expected=1", k);
      end else begin
        case (k)
          0:       e = q0.pop_front();
          1:       e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        compare(k, e);
      end
    end
  endtask

  task automatic repeat_inc(input logic [1:0] i, input int n);
    for (int j = 0; j < n; j++) step(i, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; inc = 2'b00; clr = 1'b0;
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b0, 1'b1);

    // Reset in the middle of a count.
    repeat_inc(2'b01, 37);
    step(2'b01, 1'b0, 1'b1);
    repeat_inc(2'b01, 1);

    // Top-end overflow: saturate vs wrap.
    step(2'b00, 1'b1, 1'b0);
    repeat_inc(2'b01, 98);
    repeat_inc(2'b01, 3);

    // Simultaneous carries on both channels.
    step(2'b00, 1'b1, 1'b0);
    repeat_inc(2'b01, 9);
    repeat_inc(2'b10, 19);
    repeat_inc(2'b11, 1);

    // Single winner, then lock.
    step(2'b00, 1'b1, 1'b0);
    repeat_inc(2'b10, 5);
    repeat_inc(2'b01, 10);
    repeat_inc(2'b01, 1);
    repeat_inc(2'b11, 5);

    // Tie goes to channel 0.
    step(2'b00, 1'b1, 1'b0);
    repeat_inc(2'b01, 10);
    repeat_inc(2'b10, 10);
    repeat_inc(2'b11, 1);
    repeat_inc(2'b00, 2);

    // Clear with same-cycle increments while locked, then count again.
    step(2'b11, 1'b1, 1'b0);
    repeat_inc(2'b10, 1);
    repeat_inc(2'b00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
